uart_bit_timer: RTL and testbench
=================================

UART_BIT_TIMER -- requirements
Module: uart_bit_timer

Interface
REQ-001 SHALL have parameter OVERSAMPLE, default 8: clock ticks per UART bit; legal range 4..64.
REQ-002 SHALL have parameter PRESCALE_W, default 16: width of the runtime divisor.
REQ-003 SHALL have parameter BIT_CNT_W, default 4: width of the bit index and bit count.
REQ-004 SHALL have port i_clk  input  1  clock; all state updates on the rising edge.
REQ-005 SHALL have port i_rst  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port i_enable  input  1  counters advance only while high; all counters hold while low.
REQ-007 SHALL have port i_clear  input  1  synchronous restart of all counters.
REQ-008 SHALL have port i_prescale  input  PRESCALE_W  clocks per tick.
REQ-009 SHALL have port i_num_bits  input  BIT_CNT_W  bits per frame.
REQ-010 SHALL have port i_rx  input  1  serial line, already synchronised.
REQ-011 SHALL have port o_tick  output  1  oversample tick strobe.
REQ-012 SHALL have port o_sample  output  1  mid-bit sample strobe.
REQ-013 SHALL have port o_bit_done  output  1  last tick of a bit.
REQ-014 SHALL have port o_frame_done  output  1  last tick of the last bit.
REQ-015 SHALL have port o_bit_index  output  BIT_CNT_W  current bit number.
REQ-016 SHALL have port o_rx_bit  output  1  sampled bit value.

Function
REQ-017 SHALL treat effective divisor DIV = max(i_prescale,1) and effective frame length NB = max(i_num_bits,1).
REQ-018 SHALL count prescaler pre_cnt from 0 up while enabled; o_tick = i_enable & (pre_cnt >= DIV-1); on tick pre_cnt -> 0.
REQ-019 SHALL apply the >= compare so that lowering i_prescale mid-count gives a tick on the next enabled cycle, with no wrap through 2^PRESCALE_W.
REQ-020 SHALL increment oversample counter os_cnt (0..OVERSAMPLE-1) on each o_tick and wrap to 0 after OVERSAMPLE-1.
REQ-021 SHALL decode o_sample = o_tick & (os_cnt == OVERSAMPLE/2) and o_bit_done = o_tick & (os_cnt == OVERSAMPLE-1).
REQ-022 SHALL increment o_bit_index on o_bit_done and wrap it to 0 when o_bit_index == NB-1; o_frame_done = o_bit_done & (o_bit_index == NB-1).
REQ-023 SHALL, when o_bit_index >= NB because i_num_bits was lowered mid-frame, assert o_frame_done on the next o_bit_done and wrap to 0.
REQ-024 SHALL make all strobes combinational decodes of registered counters, one cycle wide, and never asserted while i_enable is low.
REQ-025 SHALL give i_clear priority over i_enable: pre_cnt, os_cnt and o_bit_index go to 0 and no strobe asserts in that cycle; o_rx_bit holds.
REQ-026 SHALL restart timing when i_clear and i_enable are high together: the first tick occurs DIV enabled cycles after i_clear deasserts.

Reset
REQ-027 SHALL, while i_rst is low, force pre_cnt, os_cnt and o_bit_index to 0 and o_rx_bit to 1 (line idle); all strobes are 0 in reset.
REQ-028 SHALL make reset override i_clear and i_enable, and SHALL have deassertion mid-frame restart from bit 0.

Configuration
REQ-029 SHALL, with UART_BIT_TIMER_MAJORITY_EN defined, register i_rx on ticks where os_cnt is OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1, and update o_rx_bit to the 2-of-3 majority on the clock edge that ends the OVERSAMPLE/2+1 tick.
REQ-030 SHALL, without the macro, load o_rx_bit with i_rx on the o_sample edge (single sample) and SHALL omit the vote registers.

Structure
REQ-031 SHALL have uart_pkg hold the default constants UART_OVERSAMPLE_DEF=8, UART_PRESCALE_W_DEF=16 and UART_BIT_CNT_W_DEF=4, shared with the rx/tx FSMs.
REQ-032 SHALL implement the prescaler (pre_cnt, DIV clamp, o_tick) as sub-module uart_prescaler, instanced once.

Verification
REQ-033 SHALL cover: i_prescale=1, OVERSAMPLE=8, NB=2, enable held -> o_tick every cycle, o_sample cycles 4,12, o_bit_done cycles 7,15, o_frame_done cycle 15.
REQ-034 SHALL cover: i_prescale=0 -> identical to i_prescale=1; i_prescale=5 -> o_tick every 5th cycle, o_bit_done every 40 cycles.
REQ-035 SHALL cover: i_enable low for 10 cycles mid-bit -> all counters frozen, no strobes, timing resumes with no lost or extra tick.
REQ-036 SHALL cover: i_prescale dropped from 100 to 3 at pre_cnt=50 -> o_tick next enabled cycle, then every 3 cycles.
REQ-037 SHALL cover: i_clear at os_cnt=5, bit 3 -> o_bit_index=0, os_cnt=0, next o_bit_done after 8*DIV cycles; async i_rst pulse mid-frame -> o_rx_bit=1, all counters 0.
REQ-038 SHALL cover, with UART_BIT_TIMER_MAJORITY_EN: i_rx = 1,0,1 at the three samples -> o_rx_bit=1; i_rx = 0,0,1 -> o_rx_bit=0; without the macro, the single mid sample value is taken.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: constants shared by the UART bit timer and the rx/tx FSMs.
//   UART_OVERSAMPLE_DEF  default clock ticks per UART bit
//   UART_PRESCALE_W_DEF  default width of the runtime clock divisor
//   UART_BIT_CNT_W_DEF   default width of bit index / bit count
//   maj3()               2-of-3 majority helper for the sample voter
package uart_pkg;

  localparam int unsigned UART_OVERSAMPLE_DEF = 8;
  localparam int unsigned UART_PRESCALE_W_DEF = 16;
  localparam int unsigned UART_BIT_CNT_W_DEF  = 4;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_prescaler.sv
// uart_prescaler: divides i_clk down to the oversample tick rate.
//   i_clk       clock, rising edge
//   i_rst       asynchronous active-low reset
//   i_enable    counter advances only while high
//   i_clear     synchronous restart, overrides i_enable
//   i_prescale  clocks per tick (0 treated as 1)
//   o_tick      one-cycle tick strobe
module uart_prescaler #(
  parameter int unsigned PRESCALE_W = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_enable,
  input  logic                  i_clear,
  input  logic [PRESCALE_W-1:0] i_prescale,
  output logic                  o_tick
);

  logic [PRESCALE_W-1:0] div;
  logic [PRESCALE_W-1:0] pre_cnt_q, pre_cnt_d;
  logic                  hit;

  // >= rather than == so a divisor lowered below the current count
  // produces a tick at once instead of wrapping the counter.
  always_comb begin
    div    = (i_prescale == '0) ? PRESCALE_W'(1) : i_prescale;
    hit    = (pre_cnt_q >= (div - PRESCALE_W'(1)));
    o_tick = i_rst & i_enable & ~i_clear & hit;
  end

  always_comb begin
    pre_cnt_d = pre_cnt_q;
    if (i_clear) begin
      pre_cnt_d = '0;
    end else if (o_tick) begin
      pre_cnt_d = '0;
    end else if (i_enable) begin
      pre_cnt_d = pre_cnt_q + PRESCALE_W'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      pre_cnt_q <= '0;
    end else begin
      pre_cnt_q <= pre_cnt_d;
    end
  end

endmodule

// File: rtl/uart_bit_timer.sv
// uart_bit_timer: UART bit/frame timing with oversampled mid-bit sampling.
//   i_clk, i_rst      clock (rising edge), asynchronous active-low reset
//   i_enable          counters advance only while high
//   i_clear           synchronous restart of all counters (beats i_enable)
//   i_prescale        clocks per oversample tick (0 treated as 1)
//   i_num_bits        bits per frame (0 treated as 1)
//   i_rx              synchronised serial line
//   o_tick            oversample tick strobe
//   o_sample          mid-bit sample strobe
//   o_bit_done        last tick of a bit
//   o_frame_done      last tick of the last bit
//   o_bit_index       current bit number
//   o_rx_bit          sampled bit value (idle 1)
// Build option: define UART_BIT_TIMER_MAJORITY_EN for a 2-of-3 vote over
// the three ticks centred on mid-bit; otherwise a single mid-bit sample.
module uart_bit_timer
  import uart_pkg::*;
#(
  parameter int unsigned OVERSAMPLE = UART_OVERSAMPLE_DEF,
  parameter int unsigned PRESCALE_W = UART_PRESCALE_W_DEF,
  parameter int unsigned BIT_CNT_W  = UART_BIT_CNT_W_DEF
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_enable,
  input  logic                  i_clear,
  input  logic [PRESCALE_W-1:0] i_prescale,
  input  logic [BIT_CNT_W-1:0]  i_num_bits,
  input  logic                  i_rx,
  output logic                  o_tick,
  output logic                  o_sample,
  output logic                  o_bit_done,
  output logic                  o_frame_done,
  output logic [BIT_CNT_W-1:0]  o_bit_index,
  output logic                  o_rx_bit
);

  localparam int unsigned OS_W = $clog2(OVERSAMPLE);
  localparam logic [OS_W-1:0] OS_LAST = OS_W'(OVERSAMPLE - 1);
  localparam logic [OS_W-1:0] OS_MID  = OS_W'(OVERSAMPLE / 2);

  logic [OS_W-1:0]      os_cnt_q, os_cnt_d;
  logic [BIT_CNT_W-1:0] bit_idx_q, bit_idx_d;
  logic [BIT_CNT_W-1:0] nb;
  logic                 last_bit;
  logic                 rx_bit_q;

  uart_prescaler #(
    .PRESCALE_W (PRESCALE_W)
  ) u_prescaler (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_enable   (i_enable),
    .i_clear    (i_clear),
    .i_prescale (i_prescale),
    .o_tick     (o_tick)
  );

  // >= covers a frame length lowered below the current index mid-frame.
  always_comb begin
    nb           = (i_num_bits == '0) ? BIT_CNT_W'(1) : i_num_bits;
    last_bit     = (bit_idx_q >= (nb - BIT_CNT_W'(1)));
    o_sample     = o_tick & (os_cnt_q == OS_MID);
    o_bit_done   = o_tick & (os_cnt_q == OS_LAST);
    o_frame_done = o_bit_done & last_bit;
    o_bit_index  = bit_idx_q;
    o_rx_bit     = rx_bit_q;
  end

  always_comb begin
    os_cnt_d  = os_cnt_q;
    bit_idx_d = bit_idx_q;
    if (i_clear) begin
      os_cnt_d  = '0;
      bit_idx_d = '0;
    end else begin
      if (o_tick) begin
        os_cnt_d = (os_cnt_q == OS_LAST) ? '0 : os_cnt_q + OS_W'(1);
      end
      if (o_bit_done) begin
        bit_idx_d = last_bit ? '0 : bit_idx_q + BIT_CNT_W'(1);
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      os_cnt_q  <= '0;
      bit_idx_q <= '0;
    end else begin
      os_cnt_q  <= os_cnt_d;
      bit_idx_q <= bit_idx_d;
    end
  end

`ifdef UART_BIT_TIMER_MAJORITY_EN
  localparam logic [OS_W-1:0] OS_PRE  = OS_W'(OVERSAMPLE / 2 - 1);
  localparam logic [OS_W-1:0] OS_POST = OS_W'(OVERSAMPLE / 2 + 1);

  // Third vote is taken straight from i_rx on the edge that ends the
  // OS_POST tick, so only the first two samples need storage.
  logic vote0_q, vote1_q;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      vote0_q  <= 1'b1;
      vote1_q  <= 1'b1;
      rx_bit_q <= 1'b1;
    end else if (o_tick) begin
      if (os_cnt_q == OS_PRE) begin
        vote0_q <= i_rx;
      end
      if (os_cnt_q == OS_MID) begin
        vote1_q <= i_rx;
      end
      if (os_cnt_q == OS_POST) begin
        rx_bit_q <= maj3(vote0_q, vote1_q, i_rx);
      end
    end
  end
`else
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      rx_bit_q <= 1'b1;
    end else if (o_sample) begin
      rx_bit_q <= i_rx;
    end
  end
`endif

endmodule

// File: tb/tb_uart_bit_timer.sv
module tb_uart_bit_timer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en  = 1'b0;
  logic        clr = 1'b0;
  logic        rx  = 1'b1;
  logic [15:0] pre = 16'd1;
  logic [3:0]  nb  = 4'd2;

  logic       tick, smp, bd, fd, rxb;
  logic [3:0] idx;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  uart_bit_timer #(
    .OVERSAMPLE (8),
    .PRESCALE_W (16),
    .BIT_CNT_W  (4)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_enable     (en),
    .i_clear      (clr),
    .i_prescale   (pre),
    .i_num_bits   (nb),
    .i_rx         (rx),
    .o_tick       (tick),
    .o_sample     (smp),
    .o_bit_done   (bd),
    .o_frame_done (fd),
    .o_bit_index  (idx),
    .o_rx_bit     (rxb)
  );

  typedef struct {
    logic [15:0] p;
    logic [3:0]  n;
    logic        e;
    logic        c;
    logic        tick;
    logic        smp;
    logic        bd;
    logic        fd;
    logic [3:0]  idx;
  } vec_t;

  typedef struct {
    logic p3, p4, p5, other, maj, single;
  } rxpat_t;

  vec_t   tbl[32];
  rxpat_t pats[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Inputs change just after the falling edge; outputs are checked 1ns later.
  task automatic drive(input logic e, input logic c, input logic [15:0] p,
                       input logic [3:0] n, input logic r);
    @(negedge clk);
    en  = e;
    clr = c;
    pre = p;
    nb  = n;
    rx  = r;
    #1;
  endtask

  task automatic chk_strobes_low(input string name);
    chk({name, "_tick"}, 32'(tick), 32'd0);
    chk({name, "_smp"},  32'(smp),  32'd0);
    chk({name, "_bd"},   32'(bd),   32'd0);
    chk({name, "_fd"},   32'(fd),   32'd0);
  endtask

  initial begin
    int   tcount;
    logic r;
    logic exp_rx;

    // prescale 1 then 0 (must behave identically), NB=2, enable held
    for (int k = 0; k < 32; k++) begin
      int m;
      m = k % 16;
      tbl[k].p    = (k < 16) ? 16'd1 : 16'd0;
      tbl[k].n    = 4'd2;
      tbl[k].e    = 1'b1;
      tbl[k].c    = 1'b0;
      tbl[k].tick = 1'b1;
      tbl[k].smp  = (m == 4) || (m == 12);
      tbl[k].bd   = (m == 7) || (m == 15);
      tbl[k].fd   = (m == 15);
      tbl[k].idx  = (m >= 8) ? 4'd1 : 4'd0;
    end

    pats[0] = '{p3: 1'b1, p4: 1'b0, p5: 1'b1, other: 1'b0, maj: 1'b1, single: 1'b0};
    pats[1] = '{p3: 1'b0, p4: 1'b0, p5: 1'b1, other: 1'b1, maj: 1'b0, single: 1'b0};
    pats[2] = '{p3: 1'b0, p4: 1'b1, p5: 1'b0, other: 1'b1, maj: 1'b0, single: 1'b1};
    pats[3] = '{p3: 1'b1, p4: 1'b1, p5: 1'b0, other: 1'b0, maj: 1'b1, single: 1'b1};

    // Reset state: strobes stay low even with enable high and a 1-clock divisor
    drive(1'b1, 1'b0, 16'd1, 4'd2, 1'b1);
    chk_strobes_low("rst");
    chk("rst_idx", 32'(idx), 32'd0);
    chk("rst_rxb", 32'(rxb), 32'd1);
    drive(1'b0, 1'b0, 16'd1, 4'd2, 1'b1);
    rst = 1'b1;
    #1;
    chk_strobes_low("dis");

    // Table-driven main timing
    for (int k = 0; k < 32; k++) begin
      drive(tbl[k].e, tbl[k].c, tbl[k].p, tbl[k].n, 1'b1);
      chk($sformatf("tbl%0d_tick", k), 32'(tick), 32'(tbl[k].tick));
      chk($sformatf("tbl%0d_smp", k),  32'(smp),  32'(tbl[k].smp));
      chk($sformatf("tbl%0d_bd", k),   32'(bd),   32'(tbl[k].bd));
      chk($sformatf("tbl%0d_fd", k),   32'(fd),   32'(tbl[k].fd));
      chk($sformatf("tbl%0d_idx", k),  32'(idx),  32'(tbl[k].idx));
    end

    // prescale=5: tick every 5th cycle, bit done every 40
    drive(1'b1, 1'b1, 16'd5, 4'd2, 1'b1);
    chk_strobes_low("clr5");
    for (int k = 0; k < 80; k++) begin
      drive(1'b1, 1'b0, 16'd5, 4'd2, 1'b1);
      chk($sformatf("p5_%0d_tick", k), 32'(tick), 32'((k % 5) == 4));
      chk($sformatf("p5_%0d_bd", k),   32'(bd),   32'((k == 39) || (k == 79)));
      chk($sformatf("p5_%0d_fd", k),   32'(fd),   32'(k == 79));
    end

    // Enable low for 10 cycles mid-bit (prescale=3, pre_cnt=1, os_cnt=1)
    drive(1'b1, 1'b1, 16'd3, 4'd2, 1'b1);
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 1'b0, 16'd3, 4'd2, 1'b1);
      chk($sformatf("en_pre%0d_tick", k), 32'(tick), 32'(k == 2));
    end
    for (int k = 0; k < 10; k++) begin
      drive(1'b0, 1'b0, 16'd3, 4'd2, 1'b1);
      chk_strobes_low($sformatf("en_off%0d", k));
    end
    for (int r2 = 0; r2 < 20; r2++) begin
      drive(1'b1, 1'b0, 16'd3, 4'd2, 1'b1);
      chk($sformatf("en_res%0d_tick", r2), 32'(tick), 32'((r2 % 3) == 1));
      chk($sformatf("en_res%0d_smp", r2),  32'(smp),  32'(r2 == 10));
      chk($sformatf("en_res%0d_bd", r2),   32'(bd),   32'(r2 == 19));
    end

    // Prescale lowered 100 -> 3 at pre_cnt=50
    drive(1'b1, 1'b1, 16'd100, 4'd2, 1'b1);
    tcount = 0;
    for (int k = 0; k < 50; k++) begin
      drive(1'b1, 1'b0, 16'd100, 4'd2, 1'b1);
      if (tick) tcount++;
    end
    chk("p100_no_tick", 32'(tcount), 32'd0);
    for (int r2 = 0; r2 < 10; r2++) begin
      drive(1'b1, 1'b0, 16'd3, 4'd2, 1'b1);
      chk($sformatf("p3_%0d_tick", r2), 32'(tick), 32'((r2 % 3) == 0));
    end

    // Frame length lowered 4 -> 2 while on bit 3
    drive(1'b1, 1'b1, 16'd1, 4'd4, 1'b1);
    for (int k = 0; k < 24; k++) drive(1'b1, 1'b0, 16'd1, 4'd4, 1'b1);
    for (int r2 = 0; r2 < 9; r2++) begin
      drive(1'b1, 1'b0, 16'd1, 4'd2, 1'b1);
      chk($sformatf("nb_%0d_idx", r2), 32'(idx), (r2 == 8) ? 32'd0 : 32'd3);
      chk($sformatf("nb_%0d_fd", r2),  32'(fd),  32'(r2 == 7));
    end

    // Clear at bit 3, os_cnt=5, DIV=2; rx held low so o_rx_bit reads 0
    drive(1'b1, 1'b1, 16'd2, 4'd8, 1'b0);
    for (int k = 0; k < 59; k++) drive(1'b1, 1'b0, 16'd2, 4'd8, 1'b0);
    chk("clr_pre_idx", 32'(idx), 32'd3);
    chk("clr_pre_rxb", 32'(rxb), 32'd0);
    drive(1'b1, 1'b1, 16'd2, 4'd8, 1'b0);
    chk_strobes_low("clr_cyc");
    for (int r2 = 0; r2 < 17; r2++) begin
      drive(1'b1, 1'b0, 16'd2, 4'd8, 1'b0);
      chk($sformatf("clr_%0d_bd", r2),  32'(bd),  32'(r2 == 15));
      chk($sformatf("clr_%0d_idx", r2), 32'(idx), 32'(r2 == 16));
    end
    chk("clr_rxb_hold", 32'(rxb), 32'd0);

    // Asynchronous reset pulse mid-frame, between clock edges
    drive(1'b0, 1'b0, 16'd2, 4'd8, 1'b1);
    chk("arst_pre_idx", 32'(idx), 32'd1);
    rst = 1'b0;
    #1;
    chk("arst_idx", 32'(idx), 32'd0);
    chk("arst_rxb", 32'(rxb), 32'd1);
    chk_strobes_low("arst");
    rst = 1'b1;
    for (int r2 = 0; r2 < 17; r2++) begin
      drive(1'b1, 1'b0, 16'd2, 4'd8, 1'b1);
      chk($sformatf("arst_%0d_tick", r2), 32'(tick), 32'((r2 % 2) == 1));
      chk($sformatf("arst_%0d_bd", r2),   32'(bd),   32'(r2 == 15));
      chk($sformatf("arst_%0d_idx", r2),  32'(idx),  32'(r2 == 16));
    end

    // Sampled bit value: one bit period per pattern, samples at os 3,4,5
    drive(1'b1, 1'b1, 16'd1, 4'd2, 1'b1);
    for (int p = 0; p < 4; p++) begin
`ifdef UART_BIT_TIMER_MAJORITY_EN
      exp_rx = pats[p].maj;
`else
      exp_rx = pats[p].single;
`endif
      for (int k = 0; k < 8; k++) begin
        r = (k == 3) ? pats[p].p3 :
            (k == 4) ? pats[p].p4 :
            (k == 5) ? pats[p].p5 : pats[p].other;
        drive(1'b1, 1'b0, 16'd1, 4'd2, r);
        if (k >= 6) chk($sformatf("rx_pat%0d_k%0d", p, k), 32'(rxb), 32'(exp_rx));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
